apb_completer_regfile: RTL and testbench

- Synthesizable APB completer (slave) holding a bank of 32-bit-addressable control/status registers.
- Answers the transfers our APB BFM initiates: setup/access phases, optional wait states via PREADY, error response via PSLVERR.
- Sits behind the APB bridge as the default register block for peripherals; register contents are exported flat for downstream logic.

---
 rtl/apb_completer_regfile.sv | 143 ++++++++++++++
 tb/tb_apb_completer_regfile.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/apb_completer_regfile.sv
// rtl/apb_completer_regfile.sv - APB completer with a flat-exported bank of control/status registers
module apb_completer_regfile #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 8,
    parameter int WAIT_STATES    = 0,
    parameter logic [APB_DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                               apbClk,
    input  logic                               rst,
    input  logic                               PSEL,
    input  logic                               PENABLE,
    input  logic                               PWRITE,
    input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
    input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
    output logic                               PREADY,
    output logic [APB_DATA_WIDTH-1:0]          PRDATA,
    output logic                               PSLVERR,
    output logic [NUM_REGS*APB_DATA_WIDTH-1:0] regs_flat
);

    localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int WORD_W = APB_ADDR_WIDTH - 2;
    localparam logic [WORD_W-1:0] NUM_REGS_W = WORD_W'(NUM_REGS);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      pready_q, pready_d;
    logic                      pslverr_q, pslverr_d;
    logic [APB_DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                      wr_q, wr_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [APB_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                      access;

    function automatic logic addr_ok(input logic [APB_ADDR_WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a[APB_ADDR_WIDTH-1:2] < NUM_REGS_W);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [APB_ADDR_WIDTH-1:0] a);
        return a[IDX_W+1:2];
    endfunction

    assign access = PSEL & PENABLE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        regs_d    = regs_q;
        case (state_q)
            S_IDLE: begin
                // Only a true setup phase starts a transfer; PSEL&PENABLE here is ignored.
                if (PSEL && !PENABLE) begin
                    wr_d    = PWRITE;
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    if (WAIT_STATES == 0) begin
                        state_d   = S_READY;
                        pready_d  = 1'b1;
                        pslverr_d = !addr_ok(PADDR);
                        prdata_d  = (!PWRITE && addr_ok(PADDR)) ? regs_q[addr_idx(PADDR)] : '0;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!access) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d   = S_READY;
                    pready_d  = 1'b1;
                    pslverr_d = !addr_ok(addr_q);
                    prdata_d  = (!wr_q && addr_ok(addr_q)) ? regs_q[addr_idx(addr_q)] : '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_READY: begin
                if (access && wr_q && addr_ok(addr_q)) begin
                    regs_d[addr_idx(addr_q)] = wdata_q;
                end
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
            default: begin
                state_d   = S_IDLE;
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge apbClk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            regs_q    <= regs_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*APB_DATA_WIDTH +: APB_DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_apb_completer_regfile.sv
// tb/tb_apb_completer_regfile.sv - scoreboard bench for apb_completer_regfile at 0 and 3 wait states
module tb_apb_completer_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         psel, penable, pwrite, use3;
    logic [31:0]  paddr, pwdata;
    logic         psel0, psel3;
    logic         pready0, pslverr0, pready3, pslverr3;
    logic [31:0]  prdata0, prdata3;
    logic [255:0] flat0, flat3;
    logic         pready, pslverr;
    logic [31:0]  prdata;
    logic [255:0] flat;

    assign psel0   = psel & ~use3;
    assign psel3   = psel & use3;
    assign pready  = use3 ? pready3  : pready0;
    assign pslverr = use3 ? pslverr3 : pslverr0;
    assign prdata  = use3 ? prdata3  : prdata0;
    assign flat    = use3 ? flat3    : flat0;

    apb_completer_regfile #(.WAIT_STATES(0)) dut0 (
        .apbClk(clk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready0), .PRDATA(prdata0),
        .PSLVERR(pslverr0), .regs_flat(flat0)
    );

    apb_completer_regfile #(.WAIT_STATES(3)) dut3 (
        .apbClk(clk), .rst(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PREADY(pready3), .PRDATA(prdata3),
        .PSLVERR(pslverr3), .regs_flat(flat3)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m0 [8];
    logic [31:0] m3 [8];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = use3 ? m3[i] : m0[i];
        return f;
    endfunction

    task automatic clear_models();
        for (int i = 0; i < 8; i++) begin
            m0[i] = 32'h0;
            m3[i] = 32'h0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the completion edge.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input string tag);
        exp_t        e;
        exp_t        got_e;
        logic        ok;
        logic [31:0] cur;
        int          waits;
        logic        done;
        ok  = (a[1:0] == 2'b00) && (a < 32'd32);
        cur = ok ? (use3 ? m3[a[4:2]] : m0[a[4:2]]) : 32'h0;
        e.err   = !ok;
        e.rdata = (!wr && ok) ? cur : 32'h0;
        e.waits = use3 ? 3 : 0;
        sb.push_back(e);
        if (wr && ok) begin
            if (use3) m3[a[4:2]] = d;
            else      m0[a[4:2]] = d;
        end
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        paddr   = 32'h0000_0005;
        pwdata  = ~d;
        pwrite  = ~wr;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
            else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        got_e = sb.pop_front();
        if (!done) begin
            chk({tag, " timeout"}, 256'(done), 256'(1));
            psel = 1'b0; penable = 1'b0;
            @(posedge clk); #1;
            return;
        end
        chk({tag, " waits"}, 256'(waits), 256'(got_e.waits));
        chk({tag, " prdata"}, 256'(prdata), 256'(got_e.rdata));
        chk({tag, " pslverr"}, 256'(pslverr), 256'(got_e.err));
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        chk({tag, " regs_flat"}, flat, model_flat());
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; use3 = 1'b0;
        clear_models();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst pready0", 256'(pready0), 256'(0));
        chk("rst pslverr0", 256'(pslverr0), 256'(0));
        chk("rst prdata0", 256'(prdata0), 256'(0));
        chk("rst flat0", flat0, 256'(0));
        chk("rst pready3", 256'(pready3), 256'(0));
        chk("rst flat3", flat3, 256'(0));
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) xfer(1'b0, 32'(i * 4), 32'h0, $sformatf("rd%0d", i));

        xfer(1'b1, 32'h8, 32'hDEAD_BEEF, "wr8");
        xfer(1'b0, 32'h8, 32'h0, "rd8 b2b");
        chk("flat0 reg2", 256'(flat0[95:64]), 256'(32'hDEAD_BEEF));

        xfer(1'b1, 32'h20, 32'hA5A5_A5A5, "wr 0x20");
        xfer(1'b0, 32'h20, 32'h0, "rd 0x20");
        xfer(1'b1, 32'h6, 32'h5A5A_5A5A, "wr 0x6");
        xfer(1'b0, 32'h6, 32'h0, "rd 0x6");

        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle access pready", 256'(pready), 256'(0));
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 32'h8, 32'h0, "rd8 after idle access");

        use3 = 1'b1;
        xfer(1'b1, 32'h4, 32'h1234_5678, "ws3 wr4");
        xfer(1'b0, 32'h4, 32'h0, "ws3 rd4");
        xfer(1'b1, 32'h20, 32'h1111_1111, "ws3 wr 0x20");

        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("abort pready", 256'(pready), 256'(0));
        @(posedge clk); #1;
        chk("abort flat3", flat3, model_flat());
        xfer(1'b0, 32'hC, 32'h0, "ws3 rdC after abort");

        use3 = 1'b0;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("pre-rst pready", 256'(pready0), 256'(1));
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        clear_models();
        @(negedge clk);
        chk("post-rst pready", 256'(pready0), 256'(0));
        chk("post-rst reg0", 256'(flat0[31:0]), 256'(0));
        chk("post-rst flat0", flat0, 256'(0));
        chk("post-rst flat3", flat3, 256'(0));
        @(posedge clk); #1;
        xfer(1'b0, 32'h0, 32'h0, "rd0 after rst");
        xfer(1'b0, 32'h8, 32'h0, "rd8 after rst");

        chk("scoreboard empty", 256'(sb.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
